// File: rtl/pipe_hazard_pkg.sv
// pipe_hazard_pkg
//   Shared definitions for the pipeline hazard sequencer: FSM state
//   encoding and the default parameter values used by pipe_hazard_ctrl.
package pipe_hazard_pkg;

    // Encoding 2'd3 is unused; the sequencer recovers from it to RUN.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MD_WAIT = 2'd2
    } haz_state_t;

    localparam int DEF_REG_W     = 5;
    localparam int DEF_MD_CYCLES = 4;
    localparam int DEF_CNT_W     = 16;

    // Width of the inline mult/div countdown (MD_CYCLES is at most 15).
    localparam int MD_CNT_W = 4;

endpackage

// File: rtl/hazard_sat_cnt.sv
// hazard_sat_cnt
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk_i  - clock, rising edge
//     clr_i  - asynchronous clear, active-high
//     en_i   - count enable, sampled on the rising edge
//     cnt_o  - current count
module hazard_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard/stall sequencer for the 5-stage pipeline. Handles load-use
//   stalls, taken branch/jump redirects resolved in ID, and the front-end
//   hold while a multi-cycle mult/div runs.
//   Ports:
//     i_clk, i_rst           - clock; asynchronous active-high reset
//     i_ifid_rs, i_ifid_rt   - source registers of the instruction in ID
//     i_idex_rt              - destination of the instruction in EX
//     i_idex_mem_read        - EX instruction is a load
//     i_branch_taken, i_jump - ID redirect requests
//     i_md_start             - ID instruction is mult/div
//     o_pc_write, o_ifid_write, o_if_flush, o_idex_bubble, o_hold
//                            - pipeline control (Mealy: state + inputs)
//     o_state                - current FSM state
//     o_stall_cnt            - edges on which the PC was held (saturating)
//   Build option: define HAZ_STALL_CNT_EN to implement o_stall_cnt;
//   otherwise no counter flops exist and o_stall_cnt reads 0.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int REG_W     = DEF_REG_W,
    parameter int MD_CYCLES = DEF_MD_CYCLES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [REG_W-1:0] i_ifid_rs,
    input  logic [REG_W-1:0] i_ifid_rt,
    input  logic [REG_W-1:0] i_idex_rt,
    input  logic             i_idex_mem_read,
    input  logic             i_branch_taken,
    input  logic             i_jump,
    input  logic             i_md_start,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_if_flush,
    output logic             o_idex_bubble,
    output logic             o_hold,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cnt
);

    haz_state_t          state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic load_use;
    logic pc_write_c, ifid_write_c, if_flush_c, idex_bubble_c, hold_c;

    // r0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use = i_idex_mem_read && (i_idex_rt != '0) &&
                      ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));

    always_comb begin
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        if_flush_c    = 1'b0;
        idex_bubble_c = 1'b0;
        hold_c        = 1'b0;
        state_d       = state_q;
        md_cnt_d      = md_cnt_q;

        case (state_q)
            RUN: begin
                if (load_use) begin
                    // Redirects and mult/div wait until the load has moved on.
                    pc_write_c    = 1'b0;
                    ifid_write_c  = 1'b0;
                    idex_bubble_c = 1'b1;
                end else if (i_branch_taken || i_jump) begin
                    if_flush_c = 1'b1;
                    state_d    = FLUSH;
                end else if (i_md_start) begin
                    md_cnt_d = MD_CNT_W'(MD_CYCLES - 1);
                    state_d  = MD_WAIT;
                end
            end
            FLUSH: begin
                // ID holds the flushed NOP; only a load-use can still matter.
                if (load_use) begin
                    pc_write_c    = 1'b0;
                    ifid_write_c  = 1'b0;
                    idex_bubble_c = 1'b1;
                end
                state_d = RUN;
            end
            MD_WAIT: begin
                pc_write_c    = 1'b0;
                ifid_write_c  = 1'b0;
                idex_bubble_c = 1'b1;
                hold_c        = 1'b1;
                if (md_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    md_cnt_d = md_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Reset forces the idle control pattern even if hazard inputs are active.
    assign o_pc_write    = pc_write_c    | i_rst;
    assign o_ifid_write  = ifid_write_c  | i_rst;
    assign o_if_flush    = if_flush_c    & ~i_rst;
    assign o_idex_bubble = idex_bubble_c & ~i_rst;
    assign o_hold        = hold_c        & ~i_rst;
    assign o_state       = state_q;

`ifdef HAZ_STALL_CNT_EN
    hazard_sat_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i (i_clk),
        .clr_i (i_rst),
        .en_i  (~o_pc_write),
        .cnt_o (o_stall_cnt)
    );
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int REG_W     = 5;
    localparam int MD_CYCLES = 4;
    localparam int CNT_W     = 16;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [REG_W-1:0] ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
    logic             idex_mem_read = 1'b0, branch_taken = 1'b0, jump = 1'b0, md_start = 1'b0;
    logic             pc_write, ifid_write, if_flush, idex_bubble, hold;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    // Stand-alone narrow counter so the saturation boundary is reachable quickly.
    logic       sc_clr = 1'b1;
    logic       sc_en  = 1'b0;
    logic [2:0] sc_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_W     (REG_W),
        .MD_CYCLES (MD_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_ifid_rs       (ifid_rs),
        .i_ifid_rt       (ifid_rt),
        .i_idex_rt       (idex_rt),
        .i_idex_mem_read (idex_mem_read),
        .i_branch_taken  (branch_taken),
        .i_jump          (jump),
        .i_md_start      (md_start),
        .o_pc_write      (pc_write),
        .o_ifid_write    (ifid_write),
        .o_if_flush      (if_flush),
        .o_idex_bubble   (idex_bubble),
        .o_hold          (hold),
        .o_state         (state),
        .o_stall_cnt     (stall_cnt)
    );

    hazard_sat_cnt #(.W(3)) u_sc (
        .clk_i (clk),
        .clr_i (sc_clr),
        .en_i  (sc_en),
        .cnt_o (sc_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: cycles of hold left, whether the last edge took a
    // redirect, and the number of PC-held edges.
    int m_hold  = 0;
    bit m_flush = 1'b0;
    int m_stall = 0;

    function automatic bit m_lu();
        return idex_mem_read && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    endfunction

    // {pc_write, ifid_write, if_flush, idex_bubble, hold}
    function automatic logic [4:0] m_outs();
        if (rst)                                return 5'b11000;
        if (m_hold > 0)                         return 5'b00011;
        if (m_lu())                             return 5'b00010;
        if (!m_flush && (branch_taken || jump)) return 5'b11100;
        return 5'b11000;
    endfunction

    function automatic int m_state();
        if (m_hold > 0) return 2;
        if (m_flush)    return 1;
        return 0;
    endfunction

    function automatic int m_cnt();
`ifdef HAZ_STALL_CNT_EN
        return m_stall;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [4:0] e;
        if (rst) begin
            m_hold  = 0;
            m_flush = 1'b0;
            m_stall = 0;
        end else begin
            e = m_outs();
            if (!e[4] && m_stall < CNT_MAX) m_stall++;
            if (m_hold > 0) begin
                m_hold--;
                m_flush = 1'b0;
            end else if (m_lu()) begin
                m_flush = 1'b0;
            end else if (m_flush) begin
                m_flush = 1'b0;
            end else if (branch_taken || jump) begin
                m_flush = 1'b1;
            end else if (md_start) begin
                m_hold = MD_CYCLES;
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0] e;
        e = m_outs();
        check("pc_write",    32'(pc_write),    32'(e[4]));
        check("ifid_write",  32'(ifid_write),  32'(e[3]));
        check("if_flush",    32'(if_flush),    32'(e[2]));
        check("idex_bubble", 32'(idex_bubble), 32'(e[1]));
        check("hold",        32'(hold),        32'(e[0]));
        check("state",       32'(state),       32'(m_state()));
        check("stall_cnt",   32'(stall_cnt),   32'(m_cnt()));
        check("flush_and_bubble", 32'(if_flush & idex_bubble), 32'd0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input bit on);
        idex_mem_read = on;
        idex_rt       = on ? 5'd8 : 5'd0;
        ifid_rs       = on ? 5'd8 : 5'd0;
    endtask

    int held;
`ifdef HAZ_STALL_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    initial begin
        // Reset, then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("rst_pc_write",   32'(pc_write),   32'd1);
        check("rst_ifid_write", 32'(ifid_write), 32'd1);
        check("rst_state",      32'(state),      32'd0);
        check("rst_stall_cnt",  32'(stall_cnt),  32'd0);

        // Load-use stall
        cyc(); set_lu(1'b1); #2;
        check("lu_pc_write", 32'(pc_write),    32'd0);
        check("lu_bubble",   32'(idex_bubble), 32'd1);
        cyc(); set_lu(1'b0); #2;
        check("lu_stall_cnt", 32'(stall_cnt), 32'(CNT_EN * 1));

        // Load targeting r0 is no hazard
        idex_mem_read = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; #2;
        check("lu_r0_pc_write", 32'(pc_write),    32'd1);
        check("lu_r0_bubble",   32'(idex_bubble), 32'd0);
        cyc(); idex_mem_read = 1'b0;

        // Branch, then branch held during FLUSH
        branch_taken = 1'b1; #2;
        check("br_flush", 32'(if_flush), 32'd1);
        cyc(); #2;
        check("br_state_flush", 32'(state),    32'd1);
        check("br_no_reflush",  32'(if_flush), 32'd0);
        cyc(); branch_taken = 1'b0; #2;
        check("br_state_run", 32'(state), 32'd0);

        // Load-use beats branch; branch takes effect once the load moves on
        set_lu(1'b1); branch_taken = 1'b1; #2;
        check("prio_flush",    32'(if_flush), 32'd0);
        check("prio_pc_write", 32'(pc_write), 32'd0);
        cyc(); set_lu(1'b0); #2;
        check("prio_late_flush", 32'(if_flush), 32'd1);
        cyc(); branch_taken = 1'b0; #2;
        check("prio_state_flush", 32'(state), 32'd1);
        cyc(); #2;
        check("prio_state_run", 32'(state), 32'd0);

        // Mult/div hold with a jump pulsed during the hold
        md_start = 1'b1; #2;
        check("md_issue_pc_write", 32'(pc_write), 32'd1);
        check("md_issue_hold",     32'(hold),     32'd0);
        held = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            md_start = 1'b0;
            jump     = (i == 1);
            #2;
            if (hold && !pc_write) held++;
        end
        jump = 1'b0;
        check("md_held_cycles", 32'(held),      32'd4);
        check("md_stall_cnt",   32'(stall_cnt), 32'(CNT_EN * 6));
        check("md_state_run",   32'(state),     32'd0);

        // Reset in the second MD_WAIT cycle
        md_start = 1'b1;
        cyc(); md_start = 1'b0;
        cyc(); #2;
        check("mid_hold_before_rst", 32'(hold), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_hold",      32'(hold),      32'd0);
        check("mid_rst_state",     32'(state),     32'd0);
        check("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("mid_rst_pc_write",  32'(pc_write),  32'd1);
        cyc(); cyc();
        rst = 1'b0;
        cyc(); #2;
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_hold",  32'(hold),  32'd0);

        // Saturating counter boundary
        sc_clr = 1'b0;
        sc_en  = 1'b1;
        repeat (5) cyc();
        #1;
        check("satcnt_5", 32'(sc_cnt), 32'd5);
        repeat (5) cyc();
        #1;
        check("satcnt_sat", 32'(sc_cnt), 32'd7);
        sc_en = 1'b0;

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
